alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares the single combinational `alu8bit` between two requesters. Each requester offers one operation (A, B, OP) over a valid/ready handshake. The scheduler drives the ALU from registered operands and captures Result/CarryOut/ZeroFlag into a response register. That register is returned to the winning requester over a valid/ready response channel. It sits between the requesting datapath blocks and the `alu8bit` instance, and is the only driver of the ALU inputs.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_rr_scheduler_if.sv | 18 +
 rtl/alu_rr_scheduler_rr_arb2.sv | 18 +
 rtl/alu_rr_scheduler.sv | 89 ++++++++
 tb/tb_alu_rr_scheduler.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with alu8bit and the scheduler FSM state encoding
package alu_pkg;
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_INC = 3'b110;
   localparam logic [2:0] OP_DEC = 3'b111;
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;
endpackage

// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if: two request channels and one response channel of the ALU scheduler
// master: requesters/consumer side (drives req*_valid/a/b/op and rsp_ready)
// slave:  scheduler side (drives req*_ready and rsp_valid/id/result/carry/zero)
interface alu_rr_scheduler_if #(parameter int WIDTH = 8, parameter int OPW = 3);
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [OPW-1:0]   req0_op, req1_op;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero;
   logic [WIDTH-1:0] rsp_result;
   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero
   );
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero
   );
endinterface

// File: rtl/alu_rr_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter holding the last-served bit
// req_i: requests, adv_i: grant accepted (updates last-served), grant_o: one-hot or zero
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] grant_o
);
   logic last_q;
   // last_q resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk) begin
      if (!rst_n) last_q <= 1'b1;
      else if (adv_i) last_q <= grant_o[1];
   end
   assign grant_o[0] = req_i[0] & (~req_i[1] | last_q);
   assign grant_o[1] = req_i[1] & (~req_i[0] | ~last_q);
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one combinational ALU between two requesters, round-robin
// clk/rst_n: clock, sync active-low reset; bus: request/response channels (slave)
// alu_*_o: registered ALU operands; alu_*_i: ALU result/flags; done_cnt*_o: responses delivered
module alu_rr_scheduler
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 3,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_rr_scheduler_if.slave bus,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [OPW-1:0]   alu_op_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_carry_i,
   input  logic             alu_zero_i,
   output logic [CNTW-1:0]  done_cnt0_o,
   output logic [CNTW-1:0]  done_cnt1_o
);
   state_e           state_q, state_d;
   logic [1:0]       grant;
   logic             hs, rsp_fire, id_q, carry_q, zero_q;
   logic [WIDTH-1:0] a_q, b_q, result_q;
   logic [OPW-1:0]   op_q;
   logic [CNTW-1:0]  cnt0_q, cnt1_q;
   // requests are only visible to the arbiter in IDLE, so grant doubles as the handshake
   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_i   ({bus.req1_valid, bus.req0_valid} & {2{state_q == IDLE}}),
      .adv_i   (hs),
      .grant_o (grant)
   );
   assign hs             = |grant;
   assign rsp_fire       = (state_q == RESP) && bus.rsp_ready;
   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.rsp_valid  = state_q == RESP;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_carry  = carry_q;
   assign bus.rsp_zero   = zero_q;
   assign alu_a_o        = a_q;
   assign alu_b_o        = b_q;
   assign alu_op_o       = op_q;
   assign done_cnt0_o    = cnt0_q;
   assign done_cnt1_o    = cnt1_q;
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      state_d = (state_q == IDLE && hs) ? EXEC :
                (state_q == EXEC)       ? RESP :
                rsp_fire                ? IDLE : state_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         id_q     <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         if (hs) begin
            a_q  <= grant[1] ? bus.req1_a : bus.req0_a;
            b_q  <= grant[1] ? bus.req1_b : bus.req0_b;
            op_q <= grant[1] ? bus.req1_op : bus.req0_op;
            id_q <= grant[1];
         end
         // ALU has had the whole EXEC cycle to settle on the registered operands
         if (state_q == EXEC) begin
            result_q <= alu_result_i;
            carry_q  <= alu_carry_i;
            zero_q   <= alu_zero_i;
         end
         if (rsp_fire && !id_q) cnt0_q <= cnt0_q + 1'b1;
         if (rsp_fire && id_q) cnt1_q <= cnt1_q + 1'b1;
      end
   end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: randomized self-checking bench with a transaction-level reference model
module tb_alu_rr_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_op;
   logic       alu_carry, alu_zero;
   logic [3:0] done_cnt0, done_cnt1;
   int         checks = 0;
   int         errors = 0;
   int         last_srv = 1;
   logic [3:0] cnt [2] = '{4'd0, 4'd0};

   alu_rr_scheduler_if #(.WIDTH(8), .OPW(3)) bus ();

   alu_rr_scheduler #(.WIDTH(8), .OPW(3), .CNTW(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_op_o     (alu_op),
      .alu_result_i (alu_result),
      .alu_carry_i  (alu_carry),
      .alu_zero_i   (alu_zero),
      .done_cnt0_o  (done_cnt0),
      .done_cnt1_o  (done_cnt1)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, ~a};
         3'd6:    return {1'b0, a} + 9'd1;
         default: return {1'b0, a} - 9'd1;
      endcase
   endfunction

   // behavioural stand-in for alu8bit
   always_comb begin
      {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_op);
      alu_zero = alu_result == 8'h00;
   end

   // one complete operation starting in IDLE; the winner comes from the round-robin rule
   task automatic transact(input bit v0, input bit v1,
                           input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
                           input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1,
                           input int stall, input bit poke);
      int w;
      logic [8:0] r;
      logic [7:0] ea, eb;
      logic [2:0] eo;
      w  = (v0 && v1) ? (last_srv == 0 ? 1 : 0) : (v0 ? 0 : 1);
      ea = w ? a1 : a0;
      eb = w ? b1 : b0;
      eo = w ? o1 : o0;
      r  = alu_f(ea, eb, eo);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = o0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = o1;
      bus.rsp_ready  = stall == 0;
      @(negedge clk);
      checks++;
      if ({bus.req1_ready, bus.req0_ready, bus.rsp_valid} !== {w == 1, w == 0, 1'b0}) begin
         errors++;
         $display("FAIL grant: got r1,r0,rv=%b%b%b want %b%b0", bus.req1_ready, bus.req0_ready, bus.rsp_valid, w == 1, w == 0);
      end
      checks++;
      if ({done_cnt1, done_cnt0} !== {cnt[1], cnt[0]}) begin
         errors++;
         $display("FAIL done_cnt: got %0d/%0d want %0d/%0d", done_cnt0, done_cnt1, cnt[0], cnt[1]);
      end
      @(posedge clk); #1;
      if (w == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
      if (poke) begin
         if (w == 0) bus.req1_valid = 1'b1; else bus.req0_valid = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({alu_a, alu_b, alu_op, bus.req0_ready, bus.req1_ready, bus.rsp_valid} !== {ea, eb, eo, 3'b000}) begin
         errors++;
         $display("FAIL exec: got a=%h b=%h op=%0d rdy=%b%b rv=%b want a=%h b=%h op=%0d rdy=00 rv=0",
                  alu_a, alu_b, alu_op, bus.req0_ready, bus.req1_ready, bus.rsp_valid, ea, eb, eo);
      end
      @(posedge clk); #1;
      for (int i = 0; i <= stall; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.req0_ready, bus.req1_ready}
             !== {1'b1, w == 1, r[7:0], r[8], r[7:0] == 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL resp: got v=%b id=%b res=%h c=%b z=%b rdy=%b%b want v=1 id=%0d res=%h c=%b z=%b rdy=00",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero,
                     bus.req0_ready, bus.req1_ready, w, r[7:0], r[8], r[7:0] == 8'h00);
         end
         if (i < stall) begin
            @(posedge clk); #1;
            if (i == stall - 1) bus.rsp_ready = 1'b1;
         end
      end
      @(posedge clk);
      cnt[w] = cnt[w] + 4'd1;
      last_srv = w;
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero,
           alu_a, alu_b, alu_op, done_cnt0, done_cnt1} !== '0) begin
         errors++;
         $display("FAIL reset: got rdy=%b%b rv=%b id=%b res=%h c=%b z=%b a=%h b=%h op=%0d cnt=%0d/%0d want all 0",
                  bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry,
                  bus.rsp_zero, alu_a, alu_b, alu_op, done_cnt0, done_cnt1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      transact(1, 0, 8'h0A, 8'h05, 3'b000, 8'h00, 8'h00, 3'b000, 0, 0);
   endtask

   task automatic test_tie();
      transact(1, 1, 8'hFF, 8'h0F, 3'b010, 8'hF0, 8'h0F, 3'b011, 0, 0);
      transact(1, 1, 8'hFF, 8'h0F, 3'b010, 8'hF0, 8'h0F, 3'b011, 0, 0);
   endtask

   task automatic test_contention();
      for (int k = 0; k < 12; k++)
         transact(1, 1, 8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                  0, 0);
   endtask

   task automatic test_backpressure();
      transact(0, 1, 8'($urandom), 8'($urandom), 3'($urandom), 8'h01, 8'($urandom), 3'b111, 5, 1);
   endtask

   task automatic test_reset_exec();
      bus.req0_valid = 1'b1; bus.req0_a = 8'h33; bus.req0_b = 8'h44; bus.req0_op = 3'b000;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_exec_grant: got req0_ready=%b want 1", bus.req0_ready);
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt[0] = 4'd0; cnt[1] = 4'd0; last_srv = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry,
              bus.rsp_zero, alu_a, alu_b, alu_op, done_cnt0, done_cnt1} !== '0) begin
            errors++;
            $display("FAIL rst_exec: cycle %0d got rv=%b a=%h res=%h cnt=%0d/%0d want all 0",
                     i, bus.rsp_valid, alu_a, bus.rsp_result, done_cnt0, done_cnt1);
         end
         @(posedge clk); #1;
      end
      transact(0, 1, 8'h00, 8'h00, 3'b000, 8'h12, 8'h34, 3'b100, 0, 0);
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 17; k++)
         transact(1, 0, 8'($urandom), 8'($urandom), 3'($urandom), 8'h00, 8'h00, 3'b000, 0, 0);
      @(negedge clk);
      checks++;
      if ({done_cnt0, done_cnt1} !== {cnt[0], cnt[1]}) begin
         errors++;
         $display("FAIL wrap: got cnt0=%0d cnt1=%0d want %0d %0d", done_cnt0, done_cnt1, cnt[0], cnt[1]);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_contention();
      test_backpressure();
      test_reset_exec();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
